// File: rtl/arm_ctrl_pkg.sv
// Shared encodings and pipeline-register layouts for the ARM pipeline controller.
package arm_ctrl_pkg;

  localparam int ALU_W = 3;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_ORR = 3'b011;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_NONE = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic             pcsrc;
    logic             regwrite;
    logic             memtoreg;
    logic             memwrite;
    logic [ALU_W-1:0] aluctl;
    logic             alusrc;
    logic             branch;
    logic [1:0]       flagw;
    logic [3:0]       cond;
  } ctrl_t;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } mem_t;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memtoreg;
  } wb_t;

endpackage

// File: rtl/cond_check.sv
// Execute-stage condition evaluation against the NZCV flags, plus flag-write gating.
module cond_check
  import arm_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  input  logic [1:0] flagw,
  output logic       condex,
  output logic [1:0] flag_wr
);

  logic n_s, z_s, c_s, v_s;
  assign {n_s, z_s, c_s, v_s} = flags;

  // Condition-code truth table; NV never executes.
  always_comb begin
    condex = 1'b0;
    case (cond_e'(cond))
      COND_EQ: condex = z_s;
      COND_NE: condex = ~z_s;
      COND_CS: condex = c_s;
      COND_CC: condex = ~c_s;
      COND_MI: condex = n_s;
      COND_PL: condex = ~n_s;
      COND_VS: condex = v_s;
      COND_VC: condex = ~v_s;
      COND_HI: condex = c_s & ~z_s;
      COND_LS: condex = ~c_s | z_s;
      COND_GE: condex = (n_s == v_s);
      COND_LT: condex = (n_s != v_s);
      COND_GT: condex = ~z_s & (n_s == v_s);
      COND_LE: condex = z_s | (n_s != v_s);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  assign flag_wr = flagw & {2{condex}};

endmodule

// File: rtl/pipeline_controller.sv
// Control unit of the 5-stage ARM core: decode, D->E->M->W control pipeline and NZCV flags.
module pipeline_controller
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] FLAGS_RST = 4'b0000,
  parameter int         ALUCTL_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         InstrD,
  input  logic [3:0]          ALUFlagsE,
  input  logic                FlushE,
  output logic [1:0]          RegSrcD,
  output logic [1:0]          ImmSrcD,
  output logic                ALUSrcE,
  output logic [ALUCTL_W-1:0] ALUControlE,
  output logic                BranchTakenE,
  output logic                MemWriteM,
  output logic                MemtoRegW,
  output logic                PCSrcW,
  output logic                RegWriteW,
  output logic                RegWriteM,
  output logic                MemtoRegE,
  output logic                PCWrPendingF
);

  ctrl_t      ctrl_dec, de_d, de_q;
  mem_t       em_d, em_q;
  wb_t        mw_d, mw_q;
  logic [3:0] flags_d, flags_q;
  logic       cond_ex;
  logic [1:0] flag_wr;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign funct             = InstrD[25:20];
  assign unused_instr_bits = ^{InstrD[19:16], InstrD[11:0]};

  // Instruction decode; undefined data-processing commands and op=11 fall through as NOPs.
  always_comb begin
    ctrl_dec      = '0;
    ctrl_dec.cond = InstrD[31:28];
    RegSrcD       = 2'b00;
    ImmSrcD       = 2'b00;
    case (op_e'(InstrD[27:26]))
      OP_DP: begin
        ctrl_dec.alusrc = funct[5];
        case (funct[4:1])
          CMD_ADD: begin ctrl_dec.aluctl = ALU_ADD; ctrl_dec.regwrite = 1'b1; ctrl_dec.flagw = {2{funct[0]}}; end
          CMD_SUB: begin ctrl_dec.aluctl = ALU_SUB; ctrl_dec.regwrite = 1'b1; ctrl_dec.flagw = {2{funct[0]}}; end
          CMD_AND: begin ctrl_dec.aluctl = ALU_AND; ctrl_dec.regwrite = 1'b1; ctrl_dec.flagw = {funct[0], 1'b0}; end
          CMD_ORR: begin ctrl_dec.aluctl = ALU_ORR; ctrl_dec.regwrite = 1'b1; ctrl_dec.flagw = {funct[0], 1'b0}; end
          CMD_CMP: begin ctrl_dec.aluctl = ALU_SUB; ctrl_dec.flagw = 2'b11; end
          default: ctrl_dec.aluctl = ALU_ADD;
        endcase
      end
      OP_MEM: begin
        ImmSrcD         = 2'b01;
        ctrl_dec.alusrc = 1'b1;
        ctrl_dec.aluctl = funct[3] ? ALU_ADD : ALU_SUB;
        if (funct[0]) begin
          ctrl_dec.regwrite = 1'b1;
          ctrl_dec.memtoreg = 1'b1;
        end else begin
          RegSrcD           = 2'b10;
          ctrl_dec.memwrite = 1'b1;
        end
      end
      OP_BR: begin
        RegSrcD         = 2'b01;
        ImmSrcD         = 2'b10;
        ctrl_dec.alusrc = 1'b1;
        ctrl_dec.aluctl = ALU_ADD;
        ctrl_dec.branch = 1'b1;
      end
      default: ctrl_dec.alusrc = 1'b0;
    endcase
    ctrl_dec.pcsrc = ((InstrD[15:12] == 4'hF) & ctrl_dec.regwrite) | ctrl_dec.branch;
  end

  cond_check u_cond_check (
    .cond    (de_q.cond),
    .flags   (flags_q),
    .flagw   (de_q.flagw),
    .condex  (cond_ex),
    .flag_wr (flag_wr)
  );

  // Next-state for every pipeline stage; E->M side effects are squashed by a failed condition.
  always_comb begin
    de_d          = FlushE ? '0 : ctrl_dec;
    em_d.pcsrc    = de_q.pcsrc & cond_ex;
    em_d.regwrite = de_q.regwrite & cond_ex;
    em_d.memwrite = de_q.memwrite & cond_ex;
    em_d.memtoreg = de_q.memtoreg;
    mw_d.pcsrc    = em_q.pcsrc;
    mw_d.regwrite = em_q.regwrite;
    mw_d.memtoreg = em_q.memtoreg;
    flags_d[3:2]  = flag_wr[1] ? ALUFlagsE[3:2] : flags_q[3:2];
    flags_d[1:0]  = flag_wr[0] ? ALUFlagsE[1:0] : flags_q[1:0];
  end

  // Pipeline and flag registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de_q    <= '0;
      em_q    <= '0;
      mw_q    <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      de_q    <= de_d;
      em_q    <= em_d;
      mw_q    <= mw_d;
      flags_q <= flags_d;
    end
  end

  assign ALUSrcE      = de_q.alusrc;
  assign ALUControlE  = ALUCTL_W'(de_q.aluctl);
  assign MemtoRegE    = de_q.memtoreg;
  assign BranchTakenE = de_q.branch & cond_ex;
  assign MemWriteM    = em_q.memwrite;
  assign RegWriteM    = em_q.regwrite;
  assign MemtoRegW    = mw_q.memtoreg;
  assign PCSrcW       = mw_q.pcsrc;
  assign RegWriteW    = mw_q.regwrite;
  assign PCWrPendingF = ctrl_dec.pcsrc | de_q.pcsrc | em_q.pcsrc;

endmodule
